// File: rtl/axil_pkg.sv
// Shared constants and helpers for the AXI4-Lite register file: response codes,
// a constant log2 and the byte-strobe to bit-mask expansion.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Widest supported bus; narrower buses use the low slice of the helpers below.
    localparam int MAX_DATA_WIDTH = 64;
    localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic logic [MAX_DATA_WIDTH-1:0] strb_to_mask(input logic [MAX_STRB_WIDTH-1:0] strb);
        logic [MAX_DATA_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_STRB_WIDTH; i++) begin
            mask[i*8 +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/s_axil_regfile_if.sv
// AXI4-Lite bus bundle between an interconnect master and the register file slave.
interface s_axil_regfile_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axil_strb_merge.sv
// Next value of one register for a bus write: a bit takes the new data only when
// its byte strobe is set and the register allows bus writes to that bit.
module axil_strb_merge
    import axil_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] WR_MASK    = '1
)(
    input  logic [DATA_WIDTH-1:0]   old_val,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic [DATA_WIDTH-1:0]   new_val
);
    logic [DATA_WIDTH-1:0] wr_en_bits;

    assign wr_en_bits = DATA_WIDTH'(strb_to_mask(MAX_STRB_WIDTH'(wstrb))) & WR_MASK;
    assign new_val    = (old_val & ~wr_en_bits) | (wdata & wr_en_bits);
endmodule

// File: rtl/s_axil_regfile.sv
// Parametrised AXI4-Lite slave register file with per-bit write masks, hardware
// status overlay on reads, SLVERR for unmapped addresses and per-register write pulses.
module s_axil_regfile
    import axil_pkg::*;
#(
    parameter int                              ADDR_WIDTH = 8,
    parameter int                              DATA_WIDTH = 32,
    parameter int                              NUM_REGS   = 16,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VAL  = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]  WR_MASK    = '1,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RO_MASK    = '0
)(
    input  logic                               ACLK,
    input  logic                               ARESETN,
    s_axil_regfile_if.slave                    axil,
    output logic [NUM_REGS*DATA_WIDTH-1:0]     reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]     hw_status,
    output logic [NUM_REGS-1:0]                wr_pulse
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int ADDR_LSB   = clog2(STRB_WIDTH);
    localparam int IDX_WIDTH  = ADDR_WIDTH - ADDR_LSB;
    localparam int IDX_EXT    = IDX_WIDTH + 1;
    localparam logic [IDX_WIDTH:0] NUM_REGS_W = IDX_EXT'(NUM_REGS);

    logic                  aw_held_reg;
    logic [IDX_WIDTH-1:0]  aw_idx_reg;
    logic                  w_held_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_WIDTH-1:0] wstrb_reg;
    logic                  bvalid_reg;
    logic [1:0]            bresp_reg;
    logic                  rvalid_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [1:0]            rresp_reg;
    logic [NUM_REGS-1:0]   wr_pulse_reg;
    logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];

    logic [DATA_WIDTH-1:0] merged  [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd_view [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_sel_next;
    logic [DATA_WIDTH-1:0] rdata_next;
    logic [IDX_WIDTH-1:0]  ar_idx;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  ar_fire;
    logic                  commit;
    logic                  wr_mapped;
    logic                  rd_mapped;

    // Ready flags derive only from internal state, never from the master's VALIDs.
    assign axil.AWREADY = !aw_held_reg && !bvalid_reg;
    assign axil.WREADY  = !w_held_reg && !bvalid_reg;
    assign axil.ARREADY = !rvalid_reg;
    assign axil.BVALID  = bvalid_reg;
    assign axil.BRESP   = bresp_reg;
    assign axil.RVALID  = rvalid_reg;
    assign axil.RDATA   = rdata_reg;
    assign axil.RRESP   = rresp_reg;
    assign wr_pulse     = wr_pulse_reg;

    assign aw_fire   = axil.AWVALID && !aw_held_reg && !bvalid_reg;
    assign w_fire    = axil.WVALID && !w_held_reg && !bvalid_reg;
    assign ar_fire   = axil.ARVALID && !rvalid_reg;
    assign commit    = aw_held_reg && w_held_reg;
    assign ar_idx    = axil.ARADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign wr_mapped = ({1'b0, aw_idx_reg} < NUM_REGS_W);
    assign rd_mapped = ({1'b0, ar_idx} < NUM_REGS_W);

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        axil_strb_merge #(
            .DATA_WIDTH (DATA_WIDTH),
            .WR_MASK    (WR_MASK[gi*DATA_WIDTH +: DATA_WIDTH])
        ) u_merge (
            .old_val (regs_reg[gi]),
            .wdata   (wdata_reg),
            .wstrb   (wstrb_reg),
            .new_val (merged[gi])
        );

        // Status-sourced bits replace the stored bits only on the read path.
        assign rd_view[gi] = (regs_reg[gi] & ~RO_MASK[gi*DATA_WIDTH +: DATA_WIDTH])
                           | (hw_status[gi*DATA_WIDTH +: DATA_WIDTH] & RO_MASK[gi*DATA_WIDTH +: DATA_WIDTH]);
        assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs_reg[gi];
        assign wr_sel_next[gi] = commit && wr_mapped && (aw_idx_reg == IDX_WIDTH'(gi));
    end

    always_comb begin
        rdata_next = '0;
        if (rd_mapped) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ar_idx == IDX_WIDTH'(i)) begin
                    rdata_next = rd_view[i];
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel_next[i]) begin
                    regs_reg[i] <= merged[i];
                end
            end
        end
    end

    // AW and W are captured independently; the write commits once both are held.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held_reg  <= 1'b0;
            aw_idx_reg   <= '0;
            w_held_reg   <= 1'b0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= RESP_OKAY;
            wr_pulse_reg <= '0;
        end else begin
            wr_pulse_reg <= wr_sel_next;
            if (aw_fire) begin
                aw_held_reg <= 1'b1;
                aw_idx_reg  <= axil.AWADDR[ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_fire) begin
                w_held_reg <= 1'b1;
                wdata_reg  <= axil.WDATA;
                wstrb_reg  <= axil.WSTRB;
            end
            if (commit) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_reg && axil.BREADY) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end else begin
            if (ar_fire) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rdata_next;
                rresp_reg  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
            end else if (rvalid_reg && axil.RREADY) begin
                rvalid_reg <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_s_axil_regfile.sv
// Directed bench for s_axil_regfile: a vector table of single reads/writes plus
// hand-written sequences for reset, W-before-AW, backpressure and read/write collision.
module tb_s_axil_regfile;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NR = 16;

    localparam logic [NR*DW-1:0] RESET_VAL_P = {{12{32'h0}}, 32'h000000A5, 32'h11223344, 32'h0, 32'h0};
    localparam logic [NR*DW-1:0] WR_MASK_P   = {{13{32'hFFFFFFFF}}, 32'h0000FFFF, {2{32'hFFFFFFFF}}};
    localparam logic [NR*DW-1:0] RO_MASK_P   = {{15{32'h0}}, 32'hFF000000};
    localparam logic [NR*DW-1:0] AFTER_TABLE = {32'h0000F00D, {9{32'h0}}, 32'h01020304, 32'h0,
                                                32'h0000FFA5, 32'h112233DD, 32'h0, 32'h0};

    typedef logic [511:0] wide_t;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic [15:0] exp_pulse;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    logic           aclk    = 1'b0;
    logic           aresetn = 1'b0;
    logic [NR*DW-1:0] reg_out;
    logic [NR*DW-1:0] hw_status;
    logic [NR-1:0]    wr_pulse;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 aclk = ~aclk;

    s_axil_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axil ();

    s_axil_regfile #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .RESET_VAL  (RESET_VAL_P),
        .WR_MASK    (WR_MASK_P),
        .RO_MASK    (RO_MASK_P)
    ) dut (
        .ACLK      (aclk),
        .ARESETN   (aresetn),
        .axil      (axil),
        .reg_out   (reg_out),
        .hw_status (hw_status),
        .wr_pulse  (wr_pulse)
    );

    task automatic check(input string name, input wide_t act, input wide_t exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total_cnt++;
        $display("FAIL %s: got no response expected DUT handshake within bound", name);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic axil_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              output logic [1:0] resp, output logic [15:0] pulse, output bit ok);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_f;
        bit w_f;
        int cyc = 0;
        ok    = 0;
        resp  = '0;
        pulse = '0;
        axil.AWADDR  = addr;
        axil.AWVALID = 1'b1;
        axil.WDATA   = data;
        axil.WSTRB   = strb;
        axil.WVALID  = 1'b1;
        axil.BREADY  = 1'b1;
        while (!(aw_done && w_done) && cyc < 20) begin
            aw_f = axil.AWVALID && axil.AWREADY;
            w_f  = axil.WVALID && axil.WREADY;
            step();
            cyc++;
            if (aw_f) begin aw_done = 1; axil.AWVALID = 1'b0; end
            if (w_f)  begin w_done  = 1; axil.WVALID  = 1'b0; end
        end
        cyc = 0;
        while (!axil.BVALID && cyc < 20) begin
            step();
            cyc++;
        end
        if (axil.BVALID) begin
            ok    = 1;
            resp  = axil.BRESP;
            pulse = wr_pulse;
            step();
        end
        axil.AWVALID = 1'b0;
        axil.WVALID  = 1'b0;
        axil.BREADY  = 1'b0;
    endtask

    task automatic axil_read(input logic [7:0] addr, output logic [31:0] data,
                             output logic [1:0] resp, output bit ok);
        bit done = 0;
        bit f;
        int cyc = 0;
        ok   = 0;
        data = '0;
        resp = '0;
        axil.ARADDR  = addr;
        axil.ARVALID = 1'b1;
        axil.RREADY  = 1'b0;
        while (!done && cyc < 20) begin
            f = axil.ARVALID && axil.ARREADY;
            step();
            cyc++;
            if (f) done = 1;
        end
        axil.ARVALID = 1'b0;
        // Read data must be valid right after the address handshake edge.
        if (done && axil.RVALID) begin
            ok   = 1;
            data = axil.RDATA;
            resp = axil.RRESP;
            axil.RREADY = 1'b1;
            step();
            axil.RREADY = 1'b0;
        end
    endtask

    task automatic read_expect(input string name, input logic [7:0] addr,
                               input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        bit          ok;
        axil_read(addr, d, r, ok);
        if (!ok) begin
            timeout_fail(name);
        end else begin
            check({name, "_rdata"}, wide_t'(d), wide_t'(exp_data));
            check({name, "_rresp"}, wide_t'(r), wide_t'(exp_resp));
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [15:0] p;
        bit          ok;

        axil.AWADDR  = '0;
        axil.AWVALID = 1'b0;
        axil.WDATA   = '0;
        axil.WSTRB   = '0;
        axil.WVALID  = 1'b0;
        axil.BREADY  = 1'b0;
        axil.ARADDR  = '0;
        axil.ARVALID = 1'b0;
        axil.RREADY  = 1'b0;
        hw_status           = '0;
        hw_status[31:0]     = 32'h7E55AA55;
        hw_status[63:32]    = 32'hFFFFFFFF;

        vecs[0]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 2'b00, 32'h000000A5, 16'h0000};
        vecs[1]  = '{1'b0, 8'h0E, 32'h0,        4'h0, 2'b00, 32'h000000A5, 16'h0000};
        vecs[2]  = '{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'h00000000, 16'h0000};
        vecs[3]  = '{1'b1, 8'h08, 32'hAABBCCDD, 4'h5, 2'b00, 32'h0,        16'h0004};
        vecs[4]  = '{1'b0, 8'h08, 32'h0,        4'h0, 2'b00, 32'h112233DD, 16'h0000};
        vecs[5]  = '{1'b1, 8'h40, 32'h12345678, 4'hF, 2'b10, 32'h0,        16'h0000};
        vecs[6]  = '{1'b0, 8'h40, 32'h0,        4'h0, 2'b10, 32'h00000000, 16'h0000};
        vecs[7]  = '{1'b0, 8'hFC, 32'h0,        4'h0, 2'b10, 32'h00000000, 16'h0000};
        vecs[8]  = '{1'b1, 8'h3C, 32'hCAFEF00D, 4'h3, 2'b00, 32'h0,        16'h8000};
        vecs[9]  = '{1'b0, 8'h3C, 32'h0,        4'h0, 2'b00, 32'h0000F00D, 16'h0000};
        vecs[10] = '{1'b1, 8'h0C, 32'h0000FF00, 4'h2, 2'b00, 32'h0,        16'h0008};
        vecs[11] = '{1'b0, 8'h0C, 32'h0,        4'h0, 2'b00, 32'h0000FFA5, 16'h0000};
        vecs[12] = '{1'b1, 8'h14, 32'h01020304, 4'hF, 2'b00, 32'h0,        16'h0020};
        vecs[13] = '{1'b0, 8'h14, 32'h0,        4'h0, 2'b00, 32'h01020304, 16'h0000};

        // Reset phase
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_valids_c%0d", i), wide_t'({axil.BVALID, axil.RVALID}), wide_t'(2'b00));
            check($sformatf("rst_readies_c%0d", i),
                  wide_t'({axil.AWREADY, axil.WREADY, axil.ARREADY}), wide_t'(3'b111));
        end
        check("rst_reg_out", wide_t'(reg_out), wide_t'(RESET_VAL_P));
        check("rst_outs", wide_t'({wr_pulse, axil.BRESP, axil.RRESP, axil.RDATA}), wide_t'(0));
        aresetn = 1'b1;
        step();
        check("post_rst_valids", wide_t'({axil.BVALID, axil.RVALID}), wide_t'(2'b00));

        // Vector table
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                axil_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r, p, ok);
                if (!ok) begin
                    timeout_fail($sformatf("vec%0d_write", i));
                end else begin
                    check($sformatf("vec%0d_bresp", i), wide_t'(r), wide_t'(vecs[i].exp_resp));
                    check($sformatf("vec%0d_pulse", i), wide_t'(p), wide_t'(vecs[i].exp_pulse));
                end
            end else begin
                read_expect($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_resp);
            end
        end
        check("table_reg_out", wide_t'(reg_out), wide_t'(AFTER_TABLE));

        // W arrives three cycles before AW
        axil.WDATA  = 32'hDEADBEEF;
        axil.WSTRB  = 4'hF;
        axil.WVALID = 1'b1;
        check("wfirst_wready", wide_t'(axil.WREADY), wide_t'(1'b1));
        step();
        axil.WVALID = 1'b0;
        step();
        step();
        check("wfirst_wait", wide_t'({axil.AWREADY, axil.WREADY, axil.BVALID}), wide_t'(3'b100));
        axil.AWADDR  = 8'h04;
        axil.AWVALID = 1'b1;
        step();
        axil.AWVALID = 1'b0;
        check("wfirst_no_early_b", wide_t'({axil.BVALID, wr_pulse}), wide_t'(0));
        step();
        check("wfirst_b", wide_t'({axil.BVALID, axil.BRESP}), wide_t'(3'b100));
        check("wfirst_pulse", wide_t'(wr_pulse), wide_t'(16'h0002));
        step();
        check("wfirst_pulse_end", wide_t'({axil.BVALID, wr_pulse}), wide_t'({1'b1, 16'h0000}));
        axil.BREADY = 1'b1;
        step();
        axil.BREADY = 1'b0;
        check("wfirst_b_clear", wide_t'(axil.BVALID), wide_t'(1'b0));
        read_expect("wfirst_rd", 8'h04, 32'hDEADBEEF, 2'b00);

        // B backpressure with a second write waiting
        axil.AWADDR  = 8'h18;
        axil.WDATA   = 32'h11111111;
        axil.WSTRB   = 4'hF;
        axil.AWVALID = 1'b1;
        axil.WVALID  = 1'b1;
        step();
        axil.AWVALID = 1'b0;
        axil.WVALID  = 1'b0;
        step();
        axil.AWADDR  = 8'h1C;
        axil.WDATA   = 32'h22222222;
        axil.AWVALID = 1'b1;
        axil.WVALID  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold_c%0d", k),
                  wide_t'({axil.BVALID, axil.BRESP, axil.AWREADY, axil.WREADY}), wide_t'(5'b10000));
            step();
        end
        axil.BREADY = 1'b1;
        step();
        axil.BREADY = 1'b0;
        check("bp_release", wide_t'({axil.BVALID, axil.AWREADY, axil.WREADY}), wide_t'(3'b011));
        step();
        axil.AWVALID = 1'b0;
        axil.WVALID  = 1'b0;
        check("bp_second_accepted", wide_t'({axil.BVALID, axil.AWREADY, axil.WREADY}), wide_t'(3'b000));
        step();
        check("bp_second_b", wide_t'({axil.BVALID, axil.BRESP, wr_pulse}), wide_t'({3'b100, 16'h0080}));
        axil.BREADY = 1'b1;
        step();
        axil.BREADY = 1'b0;
        read_expect("bp_rd1", 8'h18, 32'h11111111, 2'b00);
        read_expect("bp_rd2", 8'h1C, 32'h22222222, 2'b00);

        // Read of reg0 on the same edge as its commit, with status-sourced top byte
        axil.AWADDR  = 8'h00;
        axil.WDATA   = 32'h12345678;
        axil.WSTRB   = 4'hF;
        axil.AWVALID = 1'b1;
        axil.WVALID  = 1'b1;
        step();
        axil.AWVALID = 1'b0;
        axil.WVALID  = 1'b0;
        axil.ARADDR  = 8'h00;
        axil.ARVALID = 1'b1;
        check("coll_arready", wide_t'(axil.ARREADY), wide_t'(1'b1));
        step();
        axil.ARVALID = 1'b0;
        check("coll_valids", wide_t'({axil.RVALID, axil.BVALID}), wide_t'(2'b11));
        check("coll_rdata", wide_t'({axil.RDATA, axil.RRESP}), wide_t'({32'h7E000000, 2'b00}));
        check("coll_reg_out", wide_t'(reg_out[31:0]), wide_t'(32'h12345678));
        axil.RREADY = 1'b1;
        axil.BREADY = 1'b1;
        step();
        axil.RREADY = 1'b0;
        axil.BREADY = 1'b0;
        check("coll_clear", wide_t'({axil.RVALID, axil.BVALID}), wide_t'(2'b00));
        read_expect("coll_next_rd", 8'h00, 32'h7E345678, 2'b00);

        // Asynchronous reset mid-cycle
        step();
        #2;
        aresetn = 1'b0;
        #1;
        check("async_rst_reg_out", wide_t'(reg_out), wide_t'(RESET_VAL_P));
        check("async_rst_rdata", wide_t'({axil.RDATA, axil.RVALID, axil.BVALID}), wide_t'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
